// File: rtl/sub_pkg.sv
// +-------------------------------------------------------------------------+
// | sub_pkg: shared FSM state type and sizing helper for the subtractor.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package sub_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sub_state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_chunk.sv
// +-------------------------------------------------------------------------+
// | sub_chunk: combinational CHUNK-bit subtract with borrow in and out.     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    // One extra bit so the borrow falls out as the MSB of the difference.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

`default_nettype wire

// File: rtl/sub_borrow_multicycle.sv
// +-------------------------------------------------------------------------+
// | sub_borrow_multicycle: WIDTH-bit subtractor processing CHUNK bits per   |
// | clock with a registered borrow ripple and valid/ready handshakes.       |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module sub_borrow_multicycle
    import sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             borrow_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
            $error("sub_borrow_multicycle: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    sub_state_t       r_state;
    sub_state_t       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_d;
    logic             w_bout;
    logic             w_last;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == c_LAST_IDX);

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in0;
                        r_b      <= in1;
                        r_borrow <= borrow_in;
                        r_idx    <= '0;
                    end
                end
                CALC: begin
                    r_diff[r_idx*CHUNK +: CHUNK] <= w_d;
                    r_borrow <= w_bout;
                    r_idx    <= r_idx + 1'b1;
                    // Top chunk's MSB is the result sign bit.
                    if (w_last) begin
                        r_borrow_out <= w_bout;
                        r_overflow   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                        (w_d[CHUNK-1] != r_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sub_borrow_multicycle.sv
// +-------------------------------------------------------------------------+
// | tb_sub_borrow_multicycle: directed and randomized self-checking bench.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_sub_borrow_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        borrow_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic [7:0]  in0_8 = '0;
    logic [7:0]  in1_8 = '0;
    logic        borrow_in_8 = 1'b0;
    logic        in_valid_8 = 1'b0;
    logic        in_ready_8;
    logic [7:0]  diff_8;
    logic        borrow_out_8;
    logic        overflow_8;
    logic        out_valid_8;
    logic        out_ready_8 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_borrow_multicycle #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in0        (in0),
        .in1        (in1),
        .borrow_in  (borrow_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    sub_borrow_multicycle #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .in0        (in0_8),
        .in1        (in1_8),
        .borrow_in  (borrow_in_8),
        .in_valid   (in_valid_8),
        .in_ready   (in_ready_8),
        .diff       (diff_8),
        .borrow_out (borrow_out_8),
        .overflow   (overflow_8),
        .out_valid  (out_valid_8),
        .out_ready  (out_ready_8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; when noisy, out_ready toggles randomly before out_valid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] exp_d, input logic exp_b,
                          input logic exp_o, input bit noisy, input int hold);
        int n;
        int lat;
        in0 = a; in1 = b; borrow_in = bin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (noisy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
        end
        out_ready = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd4);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_diff"}, {32'd0, diff}, {32'd0, exp_d});
        check({tag, "_bout"}, {63'd0, borrow_out}, {63'd0, exp_b});
        check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_o});
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, rd;
        logic        rbin, rbo, rov;

        // Reset state
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outs", {30'd0, borrow_out, overflow, diff}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_op("t1", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
        run_op("t2", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("t3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        run_op("t3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 0);
        run_op("t4", 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, 1'b0, 0);

        // Back-pressure: result held, in_valid pulses ignored
        in0 = 32'h0000_1000; in1 = 32'h0000_0001; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("t5_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            in0 = 32'hDEAD_BEEF; in1 = 32'h1234_5678; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("t5_hold_diff", {32'd0, diff}, 64'h0000_0FFF);
            check("t5_hold_rdy", {62'd0, in_ready, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_release", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk); #1;
        check("t5_no_op", {62'd0, in_ready, out_valid}, 64'd2);

        // Reset mid-CALC
        in0 = 32'h0000_00FF; in1 = 32'h0000_0000; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_partial", {32'd0, diff}, 64'h0000_00FF);
        rst = 1'b1;
        #1;
        check("t6_async", {29'd0, out_valid, borrow_out, overflow, diff}, 64'd0);
        check("t6_async_rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_rdy_after", {63'd0, in_ready}, 64'd1);
        run_op("t6_next", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 0);

        // WIDTH == CHUNK instance: single CALC cycle
        in0_8 = 8'h03; in1_8 = 8'h05; in_valid_8 = 1'b1;
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        @(posedge clk); #1;
        check("w8_a", {53'd0, out_valid_8, borrow_out_8, overflow_8, diff_8}, {53'd0, 3'b110, 8'hFE});
        out_ready_8 = 1'b1;
        in0_8 = 8'h80; in1_8 = 8'h01; in_valid_8 = 1'b1;
        @(posedge clk); #1;
        out_ready_8 = 1'b0;
        check("w8_idle", {62'd0, in_ready_8, out_valid_8}, 64'd2);
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        @(posedge clk); #1;
        check("w8_b", {53'd0, out_valid_8, borrow_out_8, overflow_8, diff_8}, {53'd0, 3'b101, 8'h7F});
        out_ready_8 = 1'b1;
        @(posedge clk); #1;
        out_ready_8 = 1'b0;

        // Randomized regression against a reference subtract
        for (int k = 0; k < 300; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
            if (k % 10 == 0) rb = ra;
            {rbo, rd} = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            rov = (ra[31] != rb[31]) && (rd[31] != ra[31]);
            run_op("rnd", ra, rb, rbin, rd, rbo, rov, 1'b1, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
